// File: rtl/rs_stream_sec_decoder_pkg.sv
// Shared types and GF(2^W) arithmetic helpers for the streaming single-symbol-error RS decoder.
package rs_stream_pkg;

    localparam int GF_MAXW = 16;

    typedef enum logic [2:0] {
        COLLECT,
        MUL,
        INV,
        FIN,
        EMIT
    } state_e;

    typedef enum logic [1:0] {
        ST_NONE   = 2'b00,
        ST_CORR   = 2'b01,
        ST_UNCORR = 2'b10
    } status_e;

    // Operands are right-aligned in GF_MAXW bits; w selects the live field width.
    function automatic logic [GF_MAXW-1:0] gf_mul(input logic [GF_MAXW-1:0] a,
                                                  input logic [GF_MAXW-1:0] b,
                                                  input int                 w,
                                                  input logic [GF_MAXW:0]   poly);
        logic [GF_MAXW:0] p;
        logic [GF_MAXW:0] topBit;
        p      = '0;
        topBit = (GF_MAXW+1)'(1) << w;
        for (int i = GF_MAXW - 1; i >= 0; i--) begin
            if (i < w) begin
                p = p << 1;
                if ((p & topBit) != '0) p = p ^ poly;
                if (b[i]) p = p ^ {1'b0, a};
            end
        end
        return p[GF_MAXW-1:0];
    endfunction

    function automatic logic [GF_MAXW-1:0] alpha_inv(input logic [GF_MAXW:0] poly);
        return poly[GF_MAXW:1];
    endfunction

endpackage

// File: rtl/rs_stream_sec_decoder_if.sv
// Symbol stream in/out bundle of the RS decoder; master is the deframer/sink side, slave the decoder.
interface rs_stream_sec_decoder_if #(parameter int W = 8) ();
    import rs_stream_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    status_e       out_status;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_status
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last, out_status
    );

endinterface

// File: rtl/rs_stream_sec_decoder_inv.sv
// Iterative GF(2^W) inverter: P^(2^W-2) built from W-1 squarings, one per cycle; inv(0)=0.
module rs_gf_inverter
    import rs_stream_pkg::*;
#(
    parameter int             W         = 8,
    parameter logic [W:0]     PRIM_POLY = 'h11D
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [W-1:0] p_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] inv_o
);

    localparam int CNTW = $clog2(W) + 1;
    localparam logic [GF_MAXW:0] POLY = (GF_MAXW+1)'(PRIM_POLY);

    function automatic logic [W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
        return W'(gf_mul(GF_MAXW'(a), GF_MAXW'(b), W, POLY));
    endfunction

    logic [W-1:0]    t_q, acc_q;
    logic [CNTW-1:0] cnt_q;
    logic            busy_q;
    logic            step;
    logic [W-1:0]    tCur, accCur, sq, accNext;
    logic [CNTW-1:0] cntCur;

    // The start cycle already performs the first iteration straight from p_i.
    always_comb begin
        step    = start_i | busy_q;
        tCur    = busy_q ? t_q : p_i;
        accCur  = busy_q ? acc_q : W'(1);
        cntCur  = busy_q ? cnt_q : '0;
        sq      = mul(tCur, tCur);
        accNext = mul(accCur, sq);
        done_o  = step & (cntCur == CNTW'(W - 2));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else if (step) begin
            t_q    <= sq;
            acc_q  <= accNext;
            cnt_q  <= cntCur + CNTW'(1);
            busy_q <= ~done_o;
        end
    end

    assign busy_o = busy_q;
    assign inv_o  = acc_q;

endmodule

// File: rtl/rs_stream_sec_decoder.sv
// Streaming RS(N) single-symbol-error corrector: collect + syndromes, solve X1/Y1, replay corrected word.
module rs_stream_sec_decoder
    import rs_stream_pkg::*;
#(
    parameter int                    SYMBOL_WIDTH = 8,
    parameter int                    N            = 18,
    parameter logic [SYMBOL_WIDTH:0] PRIM_POLY    = 'h11D
) (
    input  logic                  clk,
    input  logic                  reset,
    rs_stream_sec_decoder_if.slave io
);

    localparam int W  = SYMBOL_WIDTH;
    localparam int CW = $clog2(N) + 1;
    localparam int AW = $clog2(N);
    localparam logic [GF_MAXW:0] POLY   = (GF_MAXW+1)'(PRIM_POLY);
    localparam logic [W-1:0]     ALPHA  = W'(2);
    localparam logic [W-1:0]     ALPHA2 = W'(gf_mul(GF_MAXW'(2), GF_MAXW'(2), W, POLY));
    localparam logic [W-1:0]     AINV   = W'(alpha_inv(POLY));

    if (N <= 2 || N > (1 << SYMBOL_WIDTH) - 1) begin : g_bad_n
        $error("rs_stream_sec_decoder: N must satisfy 2 < N <= 2^W-1");
    end

    function automatic logic [W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
        return W'(gf_mul(GF_MAXW'(a), GF_MAXW'(b), W, POLY));
    endfunction

    state_e       state_q, state_d;
    logic [CW-1:0] k_q, k_d, rd_q, rd_d;
    logic [W-1:0] s1_q, s1_d, s2_q, s2_d, q_q, q_d, p_q, p_d;
    logic [W-1:0] x1_q, x1_d, y1_q, y1_d;
    logic         nz_q, nz_d, zz_q, zz_d, hitSeen_q, hitSeen_d;
    logic [W-1:0] wbuf_q [N];

    logic         inFire, hit, isLast, inReadyO, outValidO;
    logic         invStart, invBusy, invDone;
    logic [W-1:0] invVal;
    status_e      statusO;

    rs_gf_inverter #(.W(W), .PRIM_POLY(PRIM_POLY)) u_inv (
        .clk     (clk),
        .reset   (reset),
        .start_i (invStart),
        .p_i     (p_q),
        .busy_o  (invBusy),
        .done_o  (invDone),
        .inv_o   (invVal)
    );

    assign inFire   = (state_q == COLLECT) & io.in_valid;
    assign invStart = (state_q == INV) & ~invBusy;
    assign hit      = nz_q & (q_q == x1_q);
    assign isLast   = (rd_q == CW'(N - 1));

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        rd_d      = rd_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        q_d       = q_q;
        p_d       = p_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        nz_d      = nz_q;
        zz_d      = zz_q;
        hitSeen_d = hitSeen_q;
        inReadyO  = 1'b0;
        outValidO = 1'b0;
        statusO   = ST_NONE;
        case (state_q)
            COLLECT: begin
                inReadyO = 1'b1;
                if (io.in_valid) begin
                    k_d  = k_q + CW'(1);
                    s1_d = mul(s1_q, ALPHA) ^ io.in_data;
                    s2_d = mul(s2_q, ALPHA2) ^ io.in_data;
                    q_d  = (k_q == '0) ? W'(1) : mul(q_q, ALPHA);
                    if (k_q == CW'(N - 1)) state_d = MUL;
                end
            end
            MUL: begin
                p_d     = mul(s1_q, s2_q);
                state_d = INV;
            end
            INV: begin
                if (invDone) state_d = FIN;
            end
            FIN: begin
                // X1 = S2/S1 and Y1 = S1^2/S2, both via the single shared 1/(S1*S2).
                x1_d    = mul(mul(s2_q, s2_q), invVal);
                y1_d    = mul(mul(mul(s1_q, s1_q), s1_q), invVal);
                nz_d    = (s1_q != '0) & (s2_q != '0);
                zz_d    = (s1_q == '0) & (s2_q == '0);
                state_d = EMIT;
            end
            EMIT: begin
                outValidO = 1'b1;
                if (isLast) begin
                    if (zz_q)                          statusO = ST_NONE;
                    else if (nz_q & (hitSeen_q | hit)) statusO = ST_CORR;
                    else                               statusO = ST_UNCORR;
                end
                if (io.out_ready) begin
                    rd_d      = rd_q + CW'(1);
                    q_d       = mul(q_q, AINV);
                    hitSeen_d = hitSeen_q | hit;
                    if (isLast) begin
                        state_d   = COLLECT;
                        k_d       = '0;
                        rd_d      = '0;
                        hitSeen_d = 1'b0;
                        s1_d      = '0;
                        s2_d      = '0;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= COLLECT;
            k_q       <= '0;
            rd_q      <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            q_q       <= '0;
            p_q       <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            nz_q      <= 1'b0;
            zz_q      <= 1'b0;
            hitSeen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            rd_q      <= rd_d;
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            q_q       <= q_d;
            p_q       <= p_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            nz_q      <= nz_d;
            zz_q      <= zz_d;
            hitSeen_q <= hitSeen_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && inFire) wbuf_q[k_q[AW-1:0]] <= io.in_data;
    end

    assign io.in_ready   = inReadyO;
    assign io.out_valid  = outValidO;
    assign io.out_data   = wbuf_q[rd_q[AW-1:0]] ^ (hit ? y1_q : '0);
    assign io.out_last   = outValidO & isLast;
    assign io.out_status = statusO;

endmodule
